// File: rtl/fpu_vec_checker.sv
// -----------------------------------------------------------------------------
// fpu_vec_checker
//
// Purpose:
//   Vector player and checker for the fpu core. Up to DEPTH vectors
//   (op, rounding mode, operands, expected result) are loaded into a small
//   store. A run issues them one at a time to the fpu. After each issue the
//   block waits LATENCY cycles and then compares fpu_out bit-exact with the
//   expected value. It reports the error count, the first failing index and
//   pass/fail.
//
// Each vector costs LATENCY+2 cycles (ISSUE 1, WAIT LATENCY, CHECK 1).
//
// Optional feature:
//   FPU_VEC_STOP_ON_ERR_EN - when defined, the first mismatch ends the run.
//                            When not defined, the run always covers every
//                            loaded vector.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ld_valid, ld_op,        load one vector into the next free slot
//   ld_rmode, ld_opa,       (accepted only in IDLE or DONE, and only
//   ld_opb, ld_exp           when the store is not full)
//   clr                     empty the store and return to IDLE
//   start                   begin a run over all loaded vectors
//   fpu_op, fpu_rmode,      registered stimulus to the fpu
//   opa, opb
//   fpu_out                 result from the fpu
//   ld_full, vec_cnt        store status
//   busy, done, pass        run status
//   err_cnt, first_err      mismatch count and first failing index
// -----------------------------------------------------------------------------
module fpu_vec_checker #(
    parameter  int DEPTH   = 16,
    parameter  int LATENCY = 4,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_valid,
    input  logic [2:0]    ld_op,
    input  logic [1:0]    ld_rmode,
    input  logic [31:0]   ld_opa,
    input  logic [31:0]   ld_opb,
    input  logic [31:0]   ld_exp,
    input  logic          clr,
    input  logic          start,
    output logic [2:0]    fpu_op,
    output logic [1:0]    fpu_rmode,
    output logic [31:0]   opa,
    output logic [31:0]   opb,
    input  logic [31:0]   fpu_out,
    output logic          ld_full,
    output logic [AW:0]   vec_cnt,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_cnt,
    output logic [AW-1:0] first_err
);

    // Stored vector layout: {op, rmode, opa, opb, exp}
    localparam int VW = 101;
    localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [VW-1:0]   r_mem [DEPTH];
    logic [AW:0]     r_vec_cnt;
    logic            r_ld_full;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   r_last;
    logic [4:0]      r_wcnt;
    logic [AW:0]     r_err_cnt;
    logic [AW-1:0]   r_first_err;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [2:0]      r_fpu_op;
    logic [1:0]      r_fpu_rmode;
    logic [31:0]     r_opa;
    logic [31:0]     r_opb;

    logic            w_idle_or_done;
    logic            w_ld_acc;
    logic [VW-1:0]   w_rd;
    logic            w_mis;

    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    // clr has priority over a load in the same cycle
    assign w_ld_acc       = ld_valid && !clr && !r_ld_full && w_idle_or_done;
    assign w_rd           = r_mem[r_idx];
    assign w_mis          = (fpu_out != w_rd[31:0]);

    // Vector store write port; contents are not reset
    always_ff @(posedge clk) begin
        if (w_ld_acc) begin
            r_mem[r_vec_cnt[AW-1:0]] <= {ld_op, ld_rmode, ld_opa, ld_opb, ld_exp};
        end
    end

    // Control FSM with store count, run results and registered fpu stimulus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_vec_cnt   <= '0;
            r_ld_full   <= 1'b0;
            r_idx       <= '0;
            r_last      <= '0;
            r_wcnt      <= 5'd0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fpu_op    <= 3'd0;
            r_fpu_rmode <= 2'd0;
            r_opa       <= 32'd0;
            r_opb       <= 32'd0;
        end else if (clr) begin
            // Operand outputs keep the last issued vector
            r_state     <= S_IDLE;
            r_vec_cnt   <= '0;
            r_ld_full   <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            if (w_ld_acc) begin
                r_vec_cnt <= r_vec_cnt + (AW+1)'(1);
                r_ld_full <= (r_vec_cnt == (AW+1)'(DEPTH - 1));
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_err_cnt   <= '0;
                        r_first_err <= '0;
                        r_done      <= 1'b0;
                        r_idx       <= '0;
                        // Run length is latched so a load in this cycle is excluded
                        r_last      <= AW'(r_vec_cnt - (AW+1)'(1));
                        if (r_vec_cnt == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_ISSUE;
                            r_pass  <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    r_fpu_op    <= w_rd[100:98];
                    r_fpu_rmode <= w_rd[97:96];
                    r_opa       <= w_rd[95:64];
                    r_opb       <= w_rd[63:32];
                    r_wcnt      <= LAT_M1;
                    r_state     <= S_WAIT;
                end

                S_WAIT: begin
                    if (r_wcnt == 5'd0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_wcnt <= r_wcnt - 5'd1;
                    end
                end

                S_CHECK: begin
                    if (w_mis) begin
                        if (r_err_cnt != (AW+1)'(DEPTH)) begin
                            r_err_cnt <= r_err_cnt + (AW+1)'(1);
                        end
                        if (r_err_cnt == '0) begin
                            r_first_err <= r_idx;
                        end
                    end
`ifdef FPU_VEC_STOP_ON_ERR_EN
                    if (w_mis || (r_idx == r_last)) begin
`else
                    if (r_idx == r_last) begin
`endif
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_cnt == '0) && !w_mis;
                    end else begin
                        r_idx   <= r_idx + AW'(1);
                        r_state <= S_ISSUE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fpu_op    = r_fpu_op;
    assign fpu_rmode = r_fpu_rmode;
    assign opa       = r_opa;
    assign opb       = r_opb;
    assign ld_full   = r_ld_full;
    assign vec_cnt   = r_vec_cnt;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_cnt   = r_err_cnt;
    assign first_err = r_first_err;

endmodule

// File: tb/tb_fpu_vec_checker.sv
// -----------------------------------------------------------------------------
// tb_fpu_vec_checker
//
// Drives fpu_vec_checker against a fixed-latency fpu stand-in. A
// behavioural model computes every output from the elapsed cycles of the
// current run. A per-cycle compare process checks the DUT against that
// model. Directed sequences pin literal values from hand calculation.
// -----------------------------------------------------------------------------
module tb_fpu_vec_checker;

    localparam int DEPTH = 16;
    localparam int LAT   = 4;
    localparam int AW    = 4;
    localparam int P     = LAT + 2;

    localparam logic [31:0] F24 = 32'h41C00000;
    localparam logic [31:0] F4  = 32'h40800000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_valid = 1'b0;
    logic [2:0]    ld_op = 3'd0;
    logic [1:0]    ld_rmode = 2'd0;
    logic [31:0]   ld_opa = 32'd0;
    logic [31:0]   ld_opb = 32'd0;
    logic [31:0]   ld_exp = 32'd0;
    logic          clr = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    fpu_op;
    logic [1:0]    fpu_rmode;
    logic [31:0]   opa;
    logic [31:0]   opb;
    logic [31:0]   fpu_out;
    logic          ld_full;
    logic [AW:0]   vec_cnt;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_cnt;
    logic [AW-1:0] first_err;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    fpu_vec_checker #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_op(ld_op), .ld_rmode(ld_rmode),
        .ld_opa(ld_opa), .ld_opb(ld_opb), .ld_exp(ld_exp),
        .clr(clr), .start(start),
        .fpu_op(fpu_op), .fpu_rmode(fpu_rmode), .opa(opa), .opb(opb),
        .fpu_out(fpu_out),
        .ld_full(ld_full), .vec_cnt(vec_cnt), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .first_err(first_err)
    );

    always #5 clk = ~clk;

    // fpu stand-in: exact results for the 24 op 4 cases, a fixed mix otherwise
    function automatic logic [31:0] fpu_ref(input logic [2:0] op, input logic [1:0] rm,
                                            input logic [31:0] a, input logic [31:0] b);
        if (a == F24 && b == F4) begin
            case (op)
                3'd0: return 32'h41E00000;
                3'd1: return 32'h41A00000;
                3'd2: return 32'h42C00000;
                3'd3: return 32'h40C00000;
                default: ;
            endcase
        end
        return (a + {b[15:0], b[31:16]}) ^ {27'd0, rm, op} ^ 32'h5A5A0000;
    endfunction

    // fixed-latency pipeline: result valid LAT edges after operands change
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fpu_ref(fpu_op, fpu_rmode, opa, opb);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign fpu_out = pipe[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          m_run = 1'b0;
    int          m_c0 = 0;
    int          m_neff = 0;
    int          m_cnt = 0;
    logic [2:0]  m_op [DEPTH];
    logic [1:0]  m_rm [DEPTH];
    logic [31:0] m_a  [DEPTH];
    logic [31:0] m_b  [DEPTH];
    logic [31:0] m_e  [DEPTH];
    bit          m_mis [DEPTH];
    logic [68:0] m_hold = '0;

    function automatic bit m_busy();
        return m_run && ((cyc - m_c0) < m_neff * P);
    endfunction

    function automatic bit m_done();
        return m_run && ((cyc - m_c0) >= m_neff * P);
    endfunction

    function automatic int m_checked();
        int k;
        k = (cyc - m_c0) / P;
        if (k > m_neff) k = m_neff;
        return k;
    endfunction

    function automatic int m_errs();
        int e = 0;
        if (!m_run) return 0;
        for (int i = 0; i < m_checked(); i++) if (m_mis[i]) e++;
        return e;
    endfunction

    function automatic int m_first();
        if (!m_run) return 0;
        for (int i = 0; i < m_checked(); i++) if (m_mis[i]) return i;
        return 0;
    endfunction

    // operands change one cycle after each issue slot starts
    function automatic logic [68:0] m_ops();
        int t;
        int idx;
        if (!m_run || m_neff == 0) return m_hold;
        t = cyc - m_c0;
        if (t == 0) return m_hold;
        idx = (t - 1) / P;
        if (idx > m_neff - 1) idx = m_neff - 1;
        return {m_op[idx], m_rm[idx], m_a[idx], m_b[idx]};
    endfunction

    always @(posedge clk) begin
        bit b;
        int n;
        logic [68:0] cur;
        b   = m_busy();
        cur = m_ops();
        cyc++;
        if (rst_n) begin
            if (clr) begin
                m_hold = cur;
                m_run  = 1'b0;
                m_cnt  = 0;
            end else begin
                n = m_cnt;
                if (start && !b) begin
                    m_hold = cur;
                    m_run  = 1'b1;
                    m_c0   = cyc;
                    m_neff = n;
                    for (int i = 0; i < n; i++)
                        m_mis[i] = (fpu_ref(m_op[i], m_rm[i], m_a[i], m_b[i]) != m_e[i]);
`ifdef FPU_VEC_STOP_ON_ERR_EN
                    begin
                        bit hit;
                        hit = 1'b0;
                        for (int i = 0; i < n; i++) begin
                            if (!hit && m_mis[i]) begin
                                hit    = 1'b1;
                                m_neff = i + 1;
                            end
                        end
                    end
`endif
                end
                if (ld_valid && !b && m_cnt < DEPTH) begin
                    m_op[m_cnt] = ld_op;
                    m_rm[m_cnt] = ld_rmode;
                    m_a[m_cnt]  = ld_opa;
                    m_b[m_cnt]  = ld_opb;
                    m_e[m_cnt]  = ld_exp;
                    m_cnt++;
                end
            end
        end
    end

    always @(negedge rst_n) begin
        m_run  = 1'b0;
        m_cnt  = 0;
        m_hold = '0;
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        logic [68:0] eo;
        if (rst_n && chk_en) begin
            eo = m_ops();
            chk("vec_cnt",   32'(vec_cnt),   32'(m_cnt));
            chk("ld_full",   32'(ld_full),   32'(m_cnt == DEPTH));
            chk("busy",      32'(busy),      32'(m_busy()));
            chk("done",      32'(done),      32'(m_done()));
            chk("err_cnt",   32'(err_cnt),   32'(m_errs()));
            chk("first_err", 32'(first_err), 32'(m_first()));
            chk("opa",       opa,            eo[63:32]);
            chk("opb",       opb,            eo[31:0]);
            chk("op_rmode",  32'({fpu_op, fpu_rmode}), 32'(eo[68:64]));
            if (!m_run)        chk("pass_idle", 32'(pass), 32'd0);
            else if (m_done()) chk("pass",      32'(pass), 32'(m_errs() == 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [2:0] op, input logic [1:0] rm,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        ld_valid = 1'b1;
        ld_op = op; ld_rmode = rm; ld_opa = a; ld_opb = b; ld_exp = e;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic rnd_fields();
        ld_op    = 3'($urandom_range(0, 3));
        ld_rmode = 2'($urandom_range(0, 3));
        ld_opa   = $urandom;
        ld_opb   = $urandom;
        ld_exp   = ($urandom_range(0, 3) == 0) ? $urandom
                                                : fpu_ref(ld_op, ld_rmode, ld_opa, ld_opb);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // start in cycle 0; returns the cycle number in which done is first seen
    task automatic run(input int poke, input bit noise, output int cycles);
        cycles = 0;
        start  = 1'b1;
        do begin
            tick();
            cycles++;
            start = (cycles == poke);
            if (noise) begin
                rnd_fields();
                ld_valid = 1'($urandom_range(0, 1));
            end
        end while (!done && cycles < 2000);
        start    = 1'b0;
        ld_valid = 1'b0;
        chk("run_completes", 32'(done), 32'd1);
    endtask

    initial begin
        int c;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_flags", 32'({busy, done, pass, ld_full, vec_cnt, err_cnt, first_err}), 32'd0);
        chk("rst_opa", opa, 32'd0);
        chk("rst_opb", opb, 32'd0);
        chk("rst_op",  32'({fpu_op, fpu_rmode}), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // single vector
        load(3'd0, 2'd0, F24, F4, 32'h41E00000);
        run(0, 1'b0, c);
        chk("t1_done_cycle", 32'(c), 32'd7);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_err", 32'(err_cnt), 32'd0);
        chk("t1_opa_hold", opa, F24);

        // four vectors, start re-asserted mid-run
        pulse_clr();
        load(3'd0, 2'd0, F24, F4, 32'h41E00000);
        load(3'd1, 2'd0, F24, F4, 32'h41A00000);
        load(3'd2, 2'd0, F24, F4, 32'h42C00000);
        load(3'd3, 2'd0, F24, F4, 32'h40C00000);
        run(10, 1'b0, c);
        chk("t2_done_cycle", 32'(c), 32'd25);
        chk("t2_pass", 32'(pass), 32'd1);

        // two corrupted expectations (vectors 1 and 3)
        pulse_clr();
        load(3'd0, 2'd0, F24, F4, 32'h41E00000);
        load(3'd1, 2'd0, F24, F4, 32'h41A00001);
        load(3'd2, 2'd0, F24, F4, 32'h42C00000);
        load(3'd3, 2'd0, F24, F4, 32'h40C00080);
        run(0, 1'b0, c);
`ifdef FPU_VEC_STOP_ON_ERR_EN
        chk("t3_done_cycle", 32'(c), 32'd13);
        chk("t3_err", 32'(err_cnt), 32'd1);
`else
        chk("t3_done_cycle", 32'(c), 32'd25);
        chk("t3_err", 32'(err_cnt), 32'd2);
`endif
        chk("t3_first", 32'(first_err), 32'd1);
        chk("t3_pass", 32'(pass), 32'd0);

        // rerun retained store gives the same verdict
        run(0, 1'b0, c);
        chk("t3_rerun_first", 32'(first_err), 32'd1);

        // store limits
        pulse_clr();
        for (int i = 0; i < DEPTH + 2; i++) begin
            rnd_fields();
            load(ld_op, ld_rmode, ld_opa, ld_opb, ld_exp);
        end
        chk("full_flag", 32'(ld_full), 32'd1);
        chk("full_cnt", 32'(vec_cnt), 32'd16);
        run(0, 1'b0, c);
        chk("full_run_cycle", 32'(c), 32'(16 * P + 1));

        // loads during a run are ignored
        pulse_clr();
        for (int i = 0; i < 3; i++) begin
            rnd_fields();
            load(ld_op, ld_rmode, ld_opa, ld_opb, ld_exp);
        end
        start = 1'b1;
        tick();
        start    = 1'b0;
        ld_valid = 1'b1;
        repeat (5) tick();
        ld_valid = 1'b0;
        chk("ld_in_run", 32'(vec_cnt), 32'd3);
        repeat (20) tick();

        // empty store
        pulse_clr();
        run(0, 1'b0, c);
        chk("empty_cycle", 32'(c), 32'd1);
        chk("empty_pass", 32'(pass), 32'd1);

        // clr mid-run
        load(3'd2, 2'd1, F24, F4, 32'h42C00000);
        load(3'd3, 2'd1, F24, F4, 32'h40C00000);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        pulse_clr();
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_cnt", 32'(vec_cnt), 32'd0);

        // reset mid-run
        load(3'd1, 2'd2, F24, F4, 32'h41A00000);
        load(3'd0, 2'd2, F24, F4, 32'h41E00000);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_flags", 32'({busy, done, pass, ld_full, vec_cnt, err_cnt, first_err}), 32'd0);
        chk("arst_opa", opa, 32'd0);
        chk("arst_opb", opb, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // randomized runs
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 3) == 0) pulse_clr();
            repeat ($urandom_range(0, 6)) begin
                rnd_fields();
                load(ld_op, ld_rmode, ld_opa, ld_opb, ld_exp);
            end
            run(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), c);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fpu_vec_checker.md
# fpu_vec_checker

Synthesizable, parametrised vector player and checker for the `fpu` core. It stores up to `DEPTH` test vectors (op, rounding mode, operands, expected result), issues them one at a time to the `fpu`, and waits a configurable pipeline latency before comparing the result. It reports error count, first failing index and pass/fail. It replaces a free-running single-operation stimulus with a self-checking run, and can be used both on silicon and in simulation.

## Interface
Parameters:
- `DEPTH`, 16: number of vector slots; power of two, 2..256.
- `LATENCY`, 4: cycles from operands being applied to `fpu` until `fpu_out` is valid; 1..31.
- `AW`, `$clog2(DEPTH)`: index width; derived, not overridden.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ld_valid`  in  1  write one vector into the next free slot.
- `ld_op`  in  3  fpu_op (0 add, 1 sub, 2 mul, 3 div).
- `ld_rmode`  in  2  rounding mode.
- `ld_opa`, `ld_opb`  in  32  operands.
- `ld_exp`  in  32  expected result.
- `clr`  in  1  empty vector store; return to IDLE.
- `start`  in  1  begin a run over all loaded vectors.
- `fpu_op`  out  3  to fpu.
- `fpu_rmode`  out  2  to fpu.
- `opa`, `opb`  out  32  to fpu.
- `fpu_out`  in  32  from fpu.
- `ld_full`  out  1  count == DEPTH.
- `vec_cnt`  out  AW+1  number of loaded vectors.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until `start` or `clr`.
- `pass`  out  1  valid when `done`; 1 iff `err_cnt` == 0.
- `err_cnt`  out  AW+1  mismatches in the last run.
- `first_err`  out  AW  index of the first mismatch; 0 if none.

## Operation
States are IDLE, ISSUE, WAIT, CHECK and DONE.

- **Load:** accepted only in IDLE or DONE.
  - With `ld_valid`=1 and not full, the vector is written at index `vec_cnt` and `vec_cnt` increments.
  - `ld_valid` is ignored when full or busy; the store is not overwritten.
- **clr:**
  - Any state: `vec_cnt`, `err_cnt`, `first_err`, `done` and `pass` are set to 0, and the FSM goes to IDLE.
  - `clr` wins over a simultaneous `start` or `ld_valid`.
- **start:**
  - Accepted in IDLE or DONE; ignored while busy.
  - Clears `err_cnt`, `first_err` and `done`, and sets index `i`=0.
  - If `vec_cnt`==0, goes directly to DONE with `pass`=1. Otherwise goes to ISSUE.
  - A vector loaded in the same cycle as `start` is not part of the run.
- **ISSUE:** drives vector `i` onto `fpu_op`/`fpu_rmode`/`opa`/`opb` (registered), loads the wait counter with `LATENCY`-1, then goes to WAIT.
- **WAIT:** operands are held stable. The counter decrements each cycle; at 0 the FSM goes to CHECK.
- **CHECK:**
  - Compares `fpu_out` with `exp[i]` bit-exact.
  - On mismatch, `err_cnt` increments; if it was 0, `first_err` is set to `i`.
  - If `i`==`vec_cnt`-1, goes to DONE. Otherwise `i` increments and the FSM returns to ISSUE.
- **DONE:** `done`=1, `pass`=(`err_cnt`==0). The store is retained, so `start` reruns the same vectors.
- **Arithmetic:** `err_cnt` saturates at DEPTH, which cannot be exceeded. `i` never wraps, because the run ends at `vec_cnt`-1.
- **Outputs while not busy:** operand outputs hold the last issued vector; after reset they are 0.

## Timing
- **Reset values:** all outputs are 0, the state is IDLE and `vec_cnt`=0. Stored vector contents are undefined after reset.
- **Mid-run reset:** `rst_n` asserted mid-run aborts immediately; outputs take their reset values asynchronously.
- **Per-vector cost:** exactly `LATENCY`+2 cycles (ISSUE 1, WAIT `LATENCY`, CHECK 1).
  - Operands change on the clock edge that leaves ISSUE.
  - CHECK samples `fpu_out` `LATENCY` cycles after that edge.
- **Run length:** with N>0 vectors, `done` rises N·(`LATENCY`+2)+1 cycles after the cycle `start` is sampled. `busy`=1 for exactly N·(`LATENCY`+2) cycles.
- **Flag timing:** `ld_full` and `vec_cnt` update the cycle after `ld_valid`. `busy` rises the cycle after `start`.

## Configuration
- **`FPU_VEC_STOP_ON_ERR_EN` defined:** the first mismatch in CHECK ends the run and the FSM goes to DONE. The result is `err_cnt`=1, `first_err`=`i`, `pass`=0.
- **Not defined:** the full run always completes and `err_cnt` counts all mismatches.

## Test plan
The bench uses the real `fpu`, or a fixed-latency model with `LATENCY`=4.

- **Single vector:** reset, load op 0 with 0x41C00000 + 0x40800000 and exp 0x41E00000, then `start`.
  - `done` at cycle 7, `pass`=1, `err_cnt`=0.
  - `opa`/`opb` stable during WAIT.
- **Four vectors:** add 28 = 0x41E00000; sub 20 = 0x41A00000; mul 96 = 0x42C00000; div 6 = 0x40C00000.
  - `done` after 25 cycles, `pass`=1.
- **Two wrong expectations:** as above, with the expected values of vector 1 and vector 3 corrupted.
  - Without the macro: `err_cnt`=2, `first_err`=1, `pass`=0.
  - With `FPU_VEC_STOP_ON_ERR_EN`: `err_cnt`=1, `first_err`=1, `done` at cycle 13.
- **Store limits:** load DEPTH+2 vectors.
  - `ld_full`=1 and `vec_cnt`=DEPTH; the extra vectors are ignored.
  - `ld_valid` during a run leaves `vec_cnt` unchanged.
- **Empty / start while busy:** `start` with 0 vectors gives `done`=1 and `pass`=1 the next cycle. `start` re-asserted while busy has no effect on timing.
- **Abort:** `clr` mid-run gives IDLE, `vec_cnt`=0 and `busy`=0 the next cycle. `rst_n` pulled low mid-run clears all outputs immediately.
